// File: rtl/byte_sub_seq.sv
// Time-multiplexed AES SubBytes engine: NBYTES bytes pass through LANES S-box lanes per beat,
// forward or inverse per transaction, with valid/ready handshakes on both sides.
module byte_sub_seq #(
  parameter int unsigned NBYTES = 16,
  parameter int unsigned LANES  = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [8*NBYTES-1:0] in_data,
  input  logic                in_inv,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [8*NBYTES-1:0] out_data,
  output logic                busy
);

  localparam int unsigned BEATS = NBYTES / LANES;
  localparam int unsigned CW    = (BEATS > 1) ? $clog2(BEATS) : 1;

  if ((NBYTES != 4 && NBYTES != 16) || LANES == 0 || (NBYTES % LANES) != 0) begin : g_bad_param
    $error("byte_sub_seq: NBYTES must be 4 or 16 and LANES must divide NBYTES");
  end

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  // GF(2^8) multiply modulo x^8 + x^4 + x^3 + x + 1.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254; maps 0 to 0 as the S-box requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] p;
    logic [7:0] acc;
    p   = a;
    acc = 8'h01;
    for (int i = 1; i < 8; i++) begin
      p   = gf_mul(p, p);
      acc = gf_mul(acc, p);
    end
    return acc;
  endfunction

  function automatic logic [7:0] sbox_fwd(input logic [7:0] b);
    logic [7:0] v;
    v = gf_inv(b);
    return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] sbox_inv(input logic [7:0] s);
    logic [7:0] v;
    v = {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
    return gf_inv(v);
  endfunction

  state_e              r_state;
  state_e              w_state_next;
  logic [8*NBYTES-1:0] r_work;
  logic [8*NBYTES-1:0] w_work_next;
  logic [8*NBYTES-1:0] r_out;
  logic                r_inv;
  logic [CW-1:0]       r_cnt;
  logic                w_last;

  assign w_last   = (r_cnt == CW'(BEATS - 1));
  assign out_data = r_out;

  // Current beat's bytes through the lanes, merged in place over the work register.
  always_comb begin
    w_work_next = r_work;
    for (int unsigned l = 0; l < LANES; l++) begin
      w_work_next[(32'(r_cnt) * LANES + l) * 8 +: 8] =
          r_inv ? sbox_inv(r_work[(32'(r_cnt) * LANES + l) * 8 +: 8])
                : sbox_fwd(r_work[(32'(r_cnt) * LANES + l) * 8 +: 8]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    busy         = 1'b0;
    case (r_state)
      StIdle: begin
        in_ready = 1'b1;
        if (in_valid) w_state_next = StBusy;
      end
      StBusy: begin
        busy = 1'b1;
        if (w_last) w_state_next = StDone;
      end
      StDone: begin
        out_valid = 1'b1;
        if (out_ready) w_state_next = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

  // The output register only loads complete results, so partial work never leaks out.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_work <= '0;
      r_inv  <= 1'b0;
      r_cnt  <= '0;
      r_out  <= '0;
    end else begin
      case (r_state)
        StIdle: begin
          if (in_valid) begin
            r_work <= in_data;
            r_inv  <= in_inv;
            r_cnt  <= '0;
          end
        end
        StBusy: begin
          r_work <= w_work_next;
          r_cnt  <= w_last ? '0 : r_cnt + 1'b1;
          if (w_last) r_out <= w_work_next;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_byte_sub_seq.sv
// Directed bench for byte_sub_seq: four configurations driven from a vector table plus
// hand-written sequences for stall, mid-transaction reset and input changes while busy.
module tb_byte_sub_seq;

  logic                  clk;
  logic                  rst;
  logic [3:0]            in_valid;
  logic [3:0]            in_inv;
  logic [3:0]            out_ready;
  logic [3:0][127:0]     in_data;
  wire  [3:0]            in_ready;
  wire  [3:0]            out_valid;
  wire  [3:0]            busy;
  wire  [3:0][127:0]     out_data;
  wire  [31:0]           out_n4;

  int n_checks = 0;
  int n_err    = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  byte_sub_seq #(.NBYTES(16), .LANES(4)) u_l4 (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_data(in_data[0]), .in_inv(in_inv[0]), .out_valid(out_valid[0]),
    .out_ready(out_ready[0]), .out_data(out_data[0]), .busy(busy[0]));
  byte_sub_seq #(.NBYTES(16), .LANES(16)) u_l16 (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_data(in_data[1]), .in_inv(in_inv[1]), .out_valid(out_valid[1]),
    .out_ready(out_ready[1]), .out_data(out_data[1]), .busy(busy[1]));
  byte_sub_seq #(.NBYTES(16), .LANES(2)) u_l2 (
    .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .in_data(in_data[2]), .in_inv(in_inv[2]), .out_valid(out_valid[2]),
    .out_ready(out_ready[2]), .out_data(out_data[2]), .busy(busy[2]));
  byte_sub_seq #(.NBYTES(4), .LANES(1)) u_n4 (
    .clk(clk), .rst(rst), .in_valid(in_valid[3]), .in_ready(in_ready[3]),
    .in_data(in_data[3][31:0]), .in_inv(in_inv[3]), .out_valid(out_valid[3]),
    .out_ready(out_ready[3]), .out_data(out_n4), .busy(busy[3]));

  assign out_data[3] = {96'd0, out_n4};

  typedef struct {
    int           d;
    logic [127:0] din;
    logic         inv;
    logic [127:0] dexp;
    int           beats;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Accepts one transaction with out_ready low and waits (bounded) for out_valid.
  task automatic run_txn(input int d, input logic [127:0] din, input logic inv,
                         output logic [127:0] dout, output int lat, output int bcnt);
    @(negedge clk);
    check("ready_before_accept", 128'(in_ready[d]), 128'd1);
    in_data[d]   = din;
    in_inv[d]    = inv;
    in_valid[d]  = 1'b1;
    out_ready[d] = 1'b0;
    @(posedge clk); #1;
    in_valid[d] = 1'b0;
    lat  = 0;
    bcnt = 0;
    while (!out_valid[d] && lat < 64) begin
      if (busy[d]) bcnt++;
      @(posedge clk); #1;
      lat++;
    end
    dout = out_data[d];
  endtask

  task automatic release_out(input int d);
    out_ready[d] = 1'b1;
    @(posedge clk); #1;
    out_ready[d] = 1'b0;
    check("valid_drops", 128'(out_valid[d]), 128'd0);
    check("back_to_idle", 128'(in_ready[d]), 128'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [127:0] dout;
    logic [127:0] held;
    int lat;
    int bcnt;
    int c;

    vecs[0] = '{0, 128'd0, 1'b0, {16{8'h63}}, 4};
    vecs[1] = '{1, 128'hFF000000_00000000_00000000_00000153, 1'b0,
                128'h16636363_63636363_63636363_63637CED, 1};
    vecs[2] = '{1, 128'h16636363_63636363_63636363_63637CED, 1'b1,
                128'hFF000000_00000000_00000000_00000153, 1};
    vecs[3] = '{2, 128'h00010203_04050607_08090A0B_0C0D0E0F, 1'b0,
                128'h637C777B_F26B6FC5_3001672B_FED7AB76, 8};
    vecs[4] = '{2, 128'h637C777B_F26B6FC5_3001672B_FED7AB76, 1'b1,
                128'h00010203_04050607_08090A0B_0C0D0E0F, 8};
    vecs[5] = '{2, {16{8'h63}}, 1'b1, 128'd0, 8};
    vecs[6] = '{3, 128'h00000001, 1'b0, 128'h6363637C, 4};

    rst       = 1'b1;
    in_valid  = '0;
    in_inv    = '0;
    out_ready = '0;
    in_data   = '0;
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 4; d++) begin
      check("rst_in_ready", 128'(in_ready[d]), 128'd1);
      check("rst_out_valid", 128'(out_valid[d]), 128'd0);
      check("rst_busy", 128'(busy[d]), 128'd0);
      check("rst_out_data", out_data[d], 128'd0);
    end
    rst = 1'b0;

    for (int v = 0; v < 7; v++) begin
      run_txn(vecs[v].d, vecs[v].din, vecs[v].inv, dout, lat, bcnt);
      check($sformatf("vec%0d_data", v), dout, vecs[v].dexp);
      check($sformatf("vec%0d_latency", v), 128'(lat), 128'(vecs[v].beats));
      check($sformatf("vec%0d_busy_cycles", v), 128'(bcnt), 128'(vecs[v].beats));
      release_out(vecs[v].d);
    end

    // Downstream stall on the SubWord configuration.
    run_txn(3, 128'h00000001, 1'b0, dout, lat, bcnt);
    check("stall_data", dout, 128'h6363637C);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("stall_valid", 128'(out_valid[3]), 128'd1);
      check("stall_data_stable", out_data[3], 128'h6363637C);
      check("stall_in_ready", 128'(in_ready[3]), 128'd0);
    end
    release_out(3);

    // Reset during beat 2 discards the transaction and clears the held result.
    @(negedge clk);
    in_data[0]  = 128'h00010203_04050607_08090A0B_0C0D0E0F;
    in_inv[0]   = 1'b0;
    in_valid[0] = 1'b1;
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("pre_rst_busy", 128'(busy[0]), 128'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_in_ready", 128'(in_ready[0]), 128'd1);
    check("midrst_out_valid", 128'(out_valid[0]), 128'd0);
    check("midrst_busy", 128'(busy[0]), 128'd0);
    check("midrst_out_data", out_data[0], 128'd0);
    run_txn(0, 128'hFF000000_00000000_00000000_00000153, 1'b0, dout, lat, bcnt);
    check("post_rst_data", dout, 128'h16636363_63636363_63636363_63637CED);
    check("post_rst_latency", 128'(lat), 128'd4);
    release_out(0);

    // Reset and in_valid together: nothing is captured.
    @(negedge clk);
    rst         = 1'b1;
    in_valid[0] = 1'b1;
    @(posedge clk); #1;
    rst         = 1'b0;
    in_valid[0] = 1'b0;
    check("rst_wins_busy", 128'(busy[0]), 128'd0);
    check("rst_wins_ready", 128'(in_ready[0]), 128'd1);

    // Inputs change while busy and in_valid is held during DONE: result follows the capture.
    @(negedge clk);
    in_data[0]  = 128'hFF000000_00000000_00000000_00000153;
    in_inv[0]   = 1'b0;
    in_valid[0] = 1'b1;
    @(posedge clk); #1;
    c = 0;
    while (!out_valid[0] && c < 64) begin
      in_data[0] = {$urandom, $urandom, $urandom, $urandom};
      in_inv[0]  = ~in_inv[0];
      @(posedge clk); #1;
      c++;
    end
    check("toggle_latency", 128'(c), 128'd4);
    check("toggle_data", out_data[0], 128'h16636363_63636363_63636363_63637CED);
    held = out_data[0];
    for (int i = 0; i < 3; i++) begin
      in_data[0] = {$urandom, $urandom, $urandom, $urandom};
      @(posedge clk); #1;
      check("done_valid", 128'(out_valid[0]), 128'd1);
      check("done_no_capture", 128'(busy[0]), 128'd0);
      check("done_in_ready", 128'(in_ready[0]), 128'd0);
      check("done_data_stable", out_data[0], held);
    end
    out_ready[0] = 1'b1;
    @(posedge clk); #1;
    out_ready[0] = 1'b0;
    in_valid[0]  = 1'b0;
    check("after_done_idle", 128'(in_ready[0]), 128'd1);
    check("after_done_not_busy", 128'(busy[0]), 128'd0);

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
